ts_pkt_sched: RTL and testbench
===============================

Name: ts_pkt_sched

Overview:
- Round-robin packet scheduler that shares one J.83 byte-request stream among PORT_NUM ts_buf instances.
- At each 188-byte packet boundary it broadcasts ts_rd_sync to all buffers, samples their has_frame, and grants one enabled port.
- It then forwards the J.83 byte requests to the granted port's ts_rd_req and muxes the returned bytes onto a single output stream.
- When no enabled port holds a packet, it generates a null packet (PID 0x1FFF).

Parameters:
PORT_BIT, 2, width of port index
PORT_NUM, 4, number of ts_buf ports (must equal 2**PORT_BIT)
RD_LAT, 4, clk cycles from ts_rd_req pulse to valid ts_rd_out (ts_buf: 1 req delay + 1 rd_en + 2 RAM)
PKT_LEN, 188, bytes per TS packet

Ports:
clk  in  1  clock, 125 MHz
rst  in  1  reset, asynchronous, active-high
port_en  in  PORT_NUM  per-port enable; 0 = port never granted
has_frame  in  PORT_NUM  from each ts_buf
ts_rd_in  in  8*PORT_NUM  ts_rd_out of each ts_buf; port i on bits [8i+7:8i]
ts_rd_sync  out  PORT_NUM  sync pulse to each ts_buf
ts_rd_req  out  PORT_NUM  byte read request to each ts_buf
out_byte_req  in  1  one-clk pulse from J.83, one byte wanted
ts_out  out  8  output byte
ts_out_valid  out  1  one-clk strobe, ts_out valid
ts_out_sync  out  1  high with ts_out_valid on packet byte 0 (0x47)
cur_port  out  PORT_BIT  last granted port (debug)
null_pkt_cnt  out  16  null packets emitted, wraps at 0xFFFF->0
req_ovf  out  1  sticky: a byte request was lost; cleared only by rst

Behaviour:
- All outputs are registered.
- Reset: all outputs 0, state SYNC, byte_cnt 0, last_grant PORT_NUM-1, pending 0, read pipeline flushed.
- Reset mid-packet aborts the packet. No partial-packet recovery; the ts_buf reset is shared.
- FSM states and transitions:
  - SYNC: ts_rd_sync = all ones for exactly 1 clk -> WAIT.
  - WAIT: 1 clk, so ts_buf can update has_frame -> SEL.
  - SEL: compute cand = has_frame & port_en.
    - Search round-robin starting at last_grant+1, wrapping modulo PORT_NUM.
    - First hit becomes grant; last_grant and cur_port are set to it; null_mode = 0.
    - No hit: null_mode = 1; last_grant is unchanged.
    - byte_cnt = 0 -> SEND.
  - SEND: on out_byte_req or pending, issue byte byte_cnt:
    - If null_mode = 0: ts_rd_req[grant] = 1 for 1 clk.
    - Push {sync = (byte_cnt==0), null_mode, grant, null_byte} into an RD_LAT-deep shift pipeline.
    - byte_cnt increments; when byte_cnt == PKT_LEN-1 is issued -> SYNC.
    - If null_mode, null_pkt_cnt increments on the same issue.
- Request latching:
  - out_byte_req arriving in SYNC, WAIT or SEL, or in the same clk a SEND byte is issued from pending, sets pending.
  - pending is consumed by the first available SEND cycle.
  - out_byte_req while pending is already 1 is dropped and sets req_ovf.
- Null packet bytes: byte 0 = 0x47, 1 = 0x1F, 2 = 0xFF, 3 = 0x10, bytes 4..187 = 0xFF.
- Output timing: exactly RD_LAT clk after an issue, ts_out_valid = 1 for 1 clk.
  - ts_out = null_byte if the entry is null; otherwise the ts_rd_in slice of the entry's port.
  - ts_out_sync = entry sync.
  - Port and null flag travel with each entry, so in-flight bytes of packet N are not corrupted by the grant for packet N+1.
- At most 1 ts_rd_req bit is high in any clk. ts_rd_req is never asserted outside SEND.
- The grant is held for the whole packet even if port_en changes mid-packet. port_en is sampled only in SEL.
- The scheduler does not check byte 0 for 0x47; it passes data unchanged.
- Throughput: packet overhead is 3 clk (SYNC, WAIT, SEL). J.83 request spacing is ≥4 clk, so pending covers this overhead with no loss.

Test Plan:
- Single port, port_en=0001, has_frame[0]=1, 188 requests spaced 8 clk -> 188 ts_rd_req[0] pulses; ts_out_valid RD_LAT clk after each; ts_out_sync on the first only; one ts_rd_sync=1111 pulse precedes the packet.
- All 4 ports has_frame=1111, port_en=1111, 4 packets -> grants 0,1,2,3; cur_port follows; the next packet grants 0.
- has_frame=0000 -> output 47 1F FF 10 then 184×FF; null_pkt_cnt 0->1; no ts_rd_req pulse.
- has_frame=1111, port_en=0101, last_grant=0 -> grant 2, then 0; ports 1 and 3 never requested.
- out_byte_req during WAIT -> serviced as byte 0 in the first SEND clk; req_ovf stays 0. Two requests 1 clk apart during SYNC/WAIT -> req_ovf=1.
- Assert rst at byte 100 -> all outputs 0 next clk, pipeline empty (no ts_out_valid). After release, ts_rd_sync pulses and the packet restarts at byte 0 with ts_out_sync.

Source files
------------

// File: rtl/ts_pkt_sched.sv
// ts_pkt_sched: round-robin TS packet scheduler.
// Shares one J.83 byte-request stream among PORT_NUM ts_buf ports. Each
// packet opens with a sync broadcast and a grant decision. After that, byte
// requests go to the granted port and the returned bytes are muxed onto one
// output. When no enabled port holds a packet, a null packet (PID 0x1FFF) is
// generated instead.
module ts_pkt_sched #(
    parameter int PORT_BIT = 2,
    parameter int PORT_NUM = 4,
    parameter int RD_LAT   = 4,
    parameter int PKT_LEN  = 188
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PORT_NUM-1:0]   port_en,
    input  logic [PORT_NUM-1:0]   has_frame,
    input  logic [8*PORT_NUM-1:0] ts_rd_in,
    output logic [PORT_NUM-1:0]   ts_rd_sync,
    output logic [PORT_NUM-1:0]   ts_rd_req,
    input  logic                  out_byte_req,
    output logic [7:0]            ts_out,
    output logic                  ts_out_valid,
    output logic                  ts_out_sync,
    output logic [PORT_BIT-1:0]   cur_port,
    output logic [15:0]           null_pkt_cnt,
    output logic                  req_ovf
);

    localparam int CNT_W = $clog2(PKT_LEN);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        WAIT = 2'd1,
        SEL  = 2'd2,
        SEND = 2'd3
    } state_t;

    // One in-flight byte: the port and null flag travel with the byte, so a
    // new grant never retargets bytes that are still in the read pipeline.
    typedef struct packed {
        logic                valid;
        logic                sync;
        logic                is_null;
        logic [PORT_BIT-1:0] port;
        logic [7:0]          data;
    } entry_t;

    state_t              state;
    logic [CNT_W-1:0]    byte_cnt;
    logic [PORT_BIT-1:0] last_grant;
    logic [PORT_BIT-1:0] grant;
    logic                null_mode;
    logic                pending;

    logic                issue;
    logic [PORT_NUM-1:0] cand;
    logic                found;
    logic [PORT_BIT-1:0] pick;
    logic [PORT_BIT-1:0] idx;
    entry_t              new_entry;
    entry_t              pipe [RD_LAT];

    // Fixed content of the null packet: sync byte, PID 0x1FFF, payload-only
    // adaptation control with CC 0, then stuffing.
    function automatic logic [7:0] null_byte(input logic [CNT_W-1:0] pos);
        logic [7:0] b;
        case (pos)
            CNT_W'(0): b = 8'h47;
            CNT_W'(1): b = 8'h1F;
            CNT_W'(3): b = 8'h10;
            default:   b = 8'hFF;
        endcase
        return b;
    endfunction

    assign issue = (state == SEND) && (out_byte_req || pending);
    assign cand  = has_frame & port_en;

    // Round-robin search over the candidates, starting just after last_grant.
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 1; i <= PORT_NUM; i++) begin
            // PORT_NUM is a power of two, so PORT_BIT-wide addition wraps modulo PORT_NUM.
            idx = last_grant + PORT_BIT'(i);
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Build the pipeline entry for the byte being issued this cycle.
    always_comb begin
        new_entry         = '0;
        new_entry.valid   = issue;
        new_entry.sync    = (byte_cnt == '0);
        new_entry.is_null = null_mode;
        new_entry.port    = grant;
        new_entry.data    = null_byte(byte_cnt);
    end

    // Packet FSM: sync broadcast, grant, byte issue, and request latching.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SYNC;
            byte_cnt     <= '0;
            last_grant   <= PORT_BIT'(PORT_NUM - 1);
            grant        <= '0;
            null_mode    <= 1'b0;
            pending      <= 1'b0;
            ts_rd_sync   <= '0;
            ts_rd_req    <= '0;
            cur_port     <= '0;
            null_pkt_cnt <= '0;
            req_ovf      <= 1'b0;
        end else begin
            ts_rd_sync <= '0;
            ts_rd_req  <= '0;

            case (state)
                SYNC: begin
                    ts_rd_sync <= '1;
                    state      <= WAIT;
                end
                WAIT: begin
                    state <= SEL;
                end
                SEL: begin
                    if (found) begin
                        grant      <= pick;
                        last_grant <= pick;
                        cur_port   <= pick;
                        null_mode  <= 1'b0;
                    end else begin
                        null_mode  <= 1'b1;
                    end
                    byte_cnt <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    if (issue) begin
                        if (!null_mode) begin
                            ts_rd_req[grant] <= 1'b1;
                        end
                        if (byte_cnt == CNT_W'(PKT_LEN - 1)) begin
                            byte_cnt <= '0;
                            state    <= SYNC;
                            if (null_mode) begin
                                null_pkt_cnt <= null_pkt_cnt + 16'd1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= SYNC;
            endcase

            // A request that cannot be issued right away is held in pending.
            // A second one arriving while pending is full is lost.
            if (state == SEND) begin
                if (pending) begin
                    pending <= out_byte_req;
                end
            end else if (out_byte_req) begin
                if (pending) begin
                    req_ovf <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end
        end
    end

    // Read pipeline of RD_LAT stages, plus the output mux at the end of it.
    // NOTE: the pipeline is reset, not left to flush, so that a reset mid-packet
    // can never emit stale valid bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
            ts_out       <= '0;
            ts_out_valid <= 1'b0;
            ts_out_sync  <= 1'b0;
        end else begin
            pipe[0] <= new_entry;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            ts_out_valid <= pipe[RD_LAT-1].valid;
            ts_out_sync  <= pipe[RD_LAT-1].valid && pipe[RD_LAT-1].sync;
            if (!pipe[RD_LAT-1].valid) begin
                ts_out <= '0;
            end else if (pipe[RD_LAT-1].is_null) begin
                ts_out <= pipe[RD_LAT-1].data;
            end else begin
                ts_out <= ts_rd_in[8*int'(pipe[RD_LAT-1].port) +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ts_pkt_sched.sv
// tb_ts_pkt_sched: bench for the round-robin TS packet scheduler.
// A per-packet table sets the stimulus and the expected grant and counters.
// A small ts_buf model answers read requests. A scoreboard queue of expected
// bytes, each with its due cycle, is compared against ts_out as it appears.
module tb_ts_pkt_sched;

    localparam int PORT_BIT = 2;
    localparam int PORT_NUM = 4;
    localparam int RD_LAT   = 4;
    localparam int PKT_LEN  = 188;
    localparam int GAP      = 8;
    localparam int N_ROWS   = 14;

    logic                  clk;
    logic                  rst;
    logic [PORT_NUM-1:0]   port_en;
    logic [PORT_NUM-1:0]   has_frame;
    logic [8*PORT_NUM-1:0] ts_rd_in;
    logic [PORT_NUM-1:0]   ts_rd_sync;
    logic [PORT_NUM-1:0]   ts_rd_req;
    logic                  out_byte_req;
    logic [7:0]            ts_out;
    logic                  ts_out_valid;
    logic                  ts_out_sync;
    logic [PORT_BIT-1:0]   cur_port;
    logic [15:0]           null_pkt_cnt;
    logic                  req_ovf;

    ts_pkt_sched #(
        .PORT_BIT (PORT_BIT),
        .PORT_NUM (PORT_NUM),
        .RD_LAT   (RD_LAT),
        .PKT_LEN  (PKT_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .port_en      (port_en),
        .has_frame    (has_frame),
        .ts_rd_in     (ts_rd_in),
        .ts_rd_sync   (ts_rd_sync),
        .ts_rd_req    (ts_rd_req),
        .out_byte_req (out_byte_req),
        .ts_out       (ts_out),
        .ts_out_valid (ts_out_valid),
        .ts_out_sync  (ts_out_sync),
        .cur_port     (cur_port),
        .null_pkt_cnt (null_pkt_cnt),
        .req_ovf      (req_ovf)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Data a ts_buf port returns for its n-th read: port index in the top bits.
    function automatic logic [7:0] pat(input int p, input int n);
        logic [5:0] lo;
        lo = 6'((n * 5 + 1) % 64);
        return {2'(p), lo};
    endfunction

    function automatic logic [7:0] null_ref(input int k);
        case (k)
            0:       return 8'h47;
            1:       return 8'h1F;
            2:       return 8'hFF;
            3:       return 8'h10;
            default: return 8'hFF;
        endcase
    endfunction

    // ts_buf model: a request seen at edge E1 presents its byte after E3, in
    // time for the scheduler to capture it RD_LAT edges after the issue edge.
    logic [PORT_NUM-1:0] req_d1, req_d2;
    int                  buf_cnt [PORT_NUM];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            req_d1   <= '0;
            req_d2   <= '0;
            ts_rd_in <= '0;
            for (int p = 0; p < PORT_NUM; p++) buf_cnt[p] <= 0;
        end else begin
            req_d1 <= ts_rd_req;
            req_d2 <= req_d1;
            for (int p = 0; p < PORT_NUM; p++) begin
                if (req_d2[p]) begin
                    ts_rd_in[8*p +: 8] <= pat(p, buf_cnt[p]);
                    buf_cnt[p]         <= buf_cnt[p] + 1;
                end
            end
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       sync;
        int         due;
    } exp_t;

    exp_t sbq [$];
    exp_t mon_e;
    int   sb_cnt   [PORT_NUM];
    int   req_seen [PORT_NUM];
    int   sync_seen = 0;

    // Output monitor: count request/sync pulses, pop and compare each output byte.
    initial begin
        for (int p = 0; p < PORT_NUM; p++) req_seen[p] = 0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < PORT_NUM; p++) if (ts_rd_req[p]) req_seen[p]++;
            if (ts_rd_req != '0) check("rd_req_onehot", $countones(ts_rd_req), 1);
            if (ts_rd_sync != '0) begin
                sync_seen++;
                check("rd_sync_all", ts_rd_sync, 4'hF);
            end
            if (ts_out_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_valid", ts_out_valid, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("ts_out", ts_out, mon_e.data);
                    check("ts_out_sync", ts_out_sync, mon_e.sync);
                    if (mon_e.due >= 0) check("out_latency", cyc, mon_e.due);
                end
            end else if (ts_out_sync) begin
                check("sync_without_valid", ts_out_sync, 0);
            end
        end
    end

    // mode: 0 normal, 1 first request in WAIT, 2 double request in SYNC/WAIT,
    //       3 reset asserted after byte 100
    typedef struct {
        logic [3:0] en;
        logic [3:0] hf;
        logic       is_null;
        int         grant;
        int         cur;
        int         ncnt;
        logic       ovf;
        int         mode;
    } row_t;

    row_t rows [N_ROWS];

    task automatic push_exp(input row_t rw, input int k, input int due);
        exp_t e;
        if (rw.is_null) begin
            e.data = null_ref(k);
        end else begin
            e.data = pat(rw.grant, sb_cnt[rw.grant]);
            sb_cnt[rw.grant]++;
        end
        e.sync = (k == 0);
        e.due  = due;
        sbq.push_back(e);
    endtask

    task automatic run_packet(input int r);
        row_t       rw;
        int         base_req [PORT_NUM];
        int         base_sync;
        int         kstart;
        logic [3:0] onehot;
        rw        = rows[r];
        port_en   = rw.en;
        has_frame = rw.hf;
        for (int p = 0; p < PORT_NUM; p++) base_req[p] = req_seen[p];
        base_sync = sync_seen;
        onehot    = rw.is_null ? 4'b0000 : 4'(1 << rw.grant);
        kstart    = 0;

        if (rw.mode == 1) begin
            @(negedge clk);
            out_byte_req = 1'b1;
            push_exp(rw, 0, cyc + 3 + RD_LAT);
            @(negedge clk);
            out_byte_req = 1'b0;
            check("pending_no_req_in_sel", ts_rd_req, 4'b0000);
            @(negedge clk);
            check("pending_no_req_before_send", ts_rd_req, 4'b0000);
            @(negedge clk);
            check("pending_req_first_send", ts_rd_req, onehot);
            kstart = 1;
        end else if (rw.mode == 2) begin
            out_byte_req = 1'b1;
            push_exp(rw, 0, cyc + 4 + RD_LAT);
            @(negedge clk);
            @(negedge clk);
            out_byte_req = 1'b0;
            check("req_ovf_set", req_ovf, 1'b1);
            kstart = 1;
        end

        for (int k = kstart; k < PKT_LEN; k++) begin
            repeat (GAP - 1) @(negedge clk);
            if (k == PKT_LEN / 2) port_en = ~rw.en;
            out_byte_req = 1'b1;
            push_exp(rw, k, cyc + 1 + RD_LAT);
            @(negedge clk);
            out_byte_req = 1'b0;
            if (rw.mode == 3 && k == 100) begin
                #1;
                rst = 1'b1;
                sbq.delete();
                for (int p = 0; p < PORT_NUM; p++) sb_cnt[p] = 0;
                @(negedge clk);
                check("rst_mid_rd_sync", ts_rd_sync, 4'b0000);
                check("rst_mid_rd_req", ts_rd_req, 4'b0000);
                check("rst_mid_ts_out", ts_out, 8'h00);
                check("rst_mid_valid", ts_out_valid, 1'b0);
                check("rst_mid_sync", ts_out_sync, 1'b0);
                check("rst_mid_cur_port", cur_port, 2'd0);
                check("rst_mid_null_cnt", null_pkt_cnt, 16'd0);
                check("rst_mid_req_ovf", req_ovf, 1'b0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
                return;
            end
        end

        #1;
        for (int p = 0; p < PORT_NUM; p++)
            check($sformatf("rd_req_count_row%0d_p%0d", r, p), req_seen[p] - base_req[p],
                  (!rw.is_null && p == rw.grant) ? PKT_LEN : 0);
        check($sformatf("rd_sync_pulses_row%0d", r), sync_seen - base_sync, 1);
        check($sformatf("cur_port_row%0d", r), cur_port, rw.cur);
        check($sformatf("null_pkt_cnt_row%0d", r), null_pkt_cnt, rw.ncnt);
        check($sformatf("req_ovf_row%0d", r), req_ovf, rw.ovf);
    endtask

    initial begin
        //            en       hf       null  grant cur ncnt ovf  mode
        rows[0]  = '{4'b0001, 4'b0001, 1'b0, 0,    0,  0,   1'b0, 0};
        rows[1]  = '{4'b1111, 4'b1111, 1'b0, 1,    1,  0,   1'b0, 0};
        rows[2]  = '{4'b1111, 4'b1111, 1'b0, 2,    2,  0,   1'b0, 0};
        rows[3]  = '{4'b1111, 4'b1111, 1'b0, 3,    3,  0,   1'b0, 0};
        rows[4]  = '{4'b1111, 4'b1111, 1'b0, 0,    0,  0,   1'b0, 0};
        rows[5]  = '{4'b1111, 4'b0000, 1'b1, 0,    0,  1,   1'b0, 0};
        rows[6]  = '{4'b0101, 4'b1111, 1'b0, 2,    2,  1,   1'b0, 0};
        rows[7]  = '{4'b0101, 4'b1111, 1'b0, 0,    0,  1,   1'b0, 0};
        rows[8]  = '{4'b0000, 4'b1111, 1'b1, 0,    0,  2,   1'b0, 0};
        rows[9]  = '{4'b1111, 4'b1010, 1'b0, 1,    1,  2,   1'b0, 0};
        rows[10] = '{4'b1111, 4'b0100, 1'b0, 2,    2,  2,   1'b0, 1};
        rows[11] = '{4'b1111, 4'b0000, 1'b1, 0,    2,  3,   1'b1, 2};
        rows[12] = '{4'b1111, 4'b1111, 1'b0, 3,    3,  3,   1'b1, 3};
        rows[13] = '{4'b1111, 4'b1111, 1'b0, 0,    0,  0,   1'b0, 0};

        for (int p = 0; p < PORT_NUM; p++) sb_cnt[p] = 0;
        rst          = 1'b1;
        out_byte_req = 1'b0;
        port_en      = '0;
        has_frame    = '0;
        repeat (3) @(negedge clk);
        check("rst_rd_sync", ts_rd_sync, 4'b0000);
        check("rst_rd_req", ts_rd_req, 4'b0000);
        check("rst_ts_out", ts_out, 8'h00);
        check("rst_valid", ts_out_valid, 1'b0);
        check("rst_sync", ts_out_sync, 1'b0);
        check("rst_cur_port", cur_port, 2'd0);
        check("rst_null_cnt", null_pkt_cnt, 16'd0);
        check("rst_req_ovf", req_ovf, 1'b0);
        rst = 1'b0;

        for (int r = 0; r < N_ROWS; r++) run_packet(r);

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
